// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider bank: mode encoding and reset terminal count.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned DIV_RST_DEFAULT = 900000;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active and shadow (div, mode) pairs, registered output.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DIV_RST = DIV_RST_DEFAULT
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic             wr_mode_i,
  output logic             div_out_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_RST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_sh_q, div_sh_d;
  mode_e            mode_act_q, mode_act_d;
  mode_e            mode_sh_q, mode_sh_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             term;
  mode_e            wr_mode;

  assign wr_mode = mode_e'(wr_mode_i);
  assign term    = en_i && (cnt_q == div_act_q);

  // Next-state: counting, output generation, and the shadow/active reload rules.
  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_sh_d   = div_sh_q;
    mode_act_d = mode_act_q;
    mode_sh_d  = mode_sh_q;
    pend_d     = pend_q;
    out_d      = out_q;

    if (!en_i) begin
      cnt_d = '0;
      out_d = 1'b0;
      // Nothing is running, so a write can take effect at once.
      if (wr_i) begin
        div_act_d  = wr_div_i;
        mode_act_d = wr_mode;
        div_sh_d   = wr_div_i;
        mode_sh_d  = wr_mode;
        pend_d     = 1'b0;
      end
    end else begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
      if (mode_act_q == MODE_TOGGLE) begin
        out_d = term ? ~out_q : out_q;
      end else begin
        out_d = term;
      end

      if (term) begin
        // Reload only at a period boundary so no output period is cut short.
        if (wr_i) begin
          div_act_d  = wr_div_i;
          mode_act_d = wr_mode;
          div_sh_d   = wr_div_i;
          mode_sh_d  = wr_mode;
          pend_d     = 1'b0;
          if (wr_mode != mode_act_q) out_d = 1'b0;
        end else if (pend_q) begin
          div_act_d  = div_sh_q;
          mode_act_d = mode_sh_q;
          pend_d     = 1'b0;
          if (mode_sh_q != mode_act_q) out_d = 1'b0;
        end
      end else if (wr_i) begin
        div_sh_d  = wr_div_i;
        mode_sh_d = wr_mode;
        pend_d    = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; a write coincident with clr is dropped.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q      <= '0;
      div_act_q  <= DivRst;
      div_sh_q   <= DivRst;
      mode_act_q <= MODE_TOGGLE;
      mode_sh_q  <= MODE_TOGGLE;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_sh_q   <= div_sh_d;
      mode_act_q <= mode_act_d;
      mode_sh_q  <= mode_sh_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
    end
  end

  assign div_out_o = out_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of independent clock dividers sharing a free-running prescaler and a write port.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned PRE_W   = 23,
  parameter int unsigned DIV_RST = DIV_RST_DEFAULT,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_CH-1:0]  en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic [N_CH-1:0]  div_out,
  output logic [N_CH-1:0]  pend,
  output logic [PRE_W-1:0] taps
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [N_CH-1:0]  wr_sel;

  // Prescaler wraps naturally from all-ones to zero.
  always_comb begin
    pre_d = pre_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign taps = pre_q;

  // Write decode; a wr_ch of N_CH or more matches no channel and is ignored.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr_sel[i] = wr_en && (32'(wr_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_i     (clk),
      .clr_i     (clr),
      .en_i      (en[g]),
      .wr_i      (wr_sel[g]),
      .wr_div_i  (wr_div),
      .wr_mode_i (wr_mode),
      .div_out_o (div_out[g]),
      .pend_o    (pend[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed self-checking bench for clkdiv_bank.
module tb_clkdiv_bank;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned PRE_W = 23;

  logic             clk;
  logic             clr;
  logic [N_CH-1:0]  en;
  logic             wr_en;
  logic [1:0]       wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic [N_CH-1:0]  div_out;
  logic [N_CH-1:0]  pend;
  logic [PRE_W-1:0] taps;

  int n_cmp = 0;
  int n_err = 0;

  clkdiv_bank #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .wr_mode (wr_mode),
    .div_out (div_out),
    .pend    (pend),
    .taps    (taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int div, input logic mode);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_div  = CNT_W'(div);
    wr_mode = mode;
    tick();
    wr_en   = 1'b0;
  endtask

  // Number of consecutive samples (starting now) where div_out[ch] == val.
  task automatic run_len(input int ch, input logic val, output int len);
    len = 0;
    while (div_out[ch] == val && len < 100) begin
      len++;
      tick();
    end
  endtask

  // Advance until the first sample where div_out[ch] has just risen.
  task automatic wait_rise(input int ch, output int found);
    logic prev;
    found = 0;
    for (int k = 0; k < 300; k++) begin
      prev = div_out[ch];
      tick();
      if (!prev && div_out[ch]) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    int       len;
    int       found;
    int       hc;
    logic [3:0] tp;

    clr = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
    tick();
    tick();
    check_eq("rst_div_out", 32'(div_out), 0);
    check_eq("rst_pend", 32'(pend), 0);
    check_eq("rst_taps", 32'(taps), 0);

    // Prescaler counts from 0 after reset release; taps[0] alternates each cycle.
    clr = 1'b0;
    tick();
    check_eq("taps_first", 32'(taps), 1);
    for (int i = 0; i < 4; i++) begin
      tp[i] = taps[0];
      if (i < 3) tick();
    end
    check_eq("taps0_pattern", 32'(tp), 32'b0101);
    check_eq("taps_count", 32'(taps), 4);

    // ch0 div = 3 toggle: 4 high / 4 low.
    do_write(0, 3, 1'b0);
    check_eq("pend_disabled_write", 32'(pend), 0);
    en = 4'b0001;
    wait_rise(0, found);
    check_eq("ch0_rise", 32'(found), 1);
    run_len(0, 1'b1, len); check_eq("ch0_d3_high", 32'(len), 4);
    run_len(0, 1'b0, len); check_eq("ch0_d3_low", 32'(len), 4);
    run_len(0, 1'b1, len); check_eq("ch0_d3_high2", 32'(len), 4);

    // ch1 div = 4 pulse: one high cycle every 5.
    do_write(1, 4, 1'b1);
    en = 4'b0011;
    wait_rise(1, found);
    check_eq("ch1_rise", 32'(found), 1);
    run_len(1, 1'b1, len); check_eq("ch1_pulse_high", 32'(len), 1);
    run_len(1, 1'b0, len); check_eq("ch1_pulse_low", 32'(len), 4);
    run_len(1, 1'b1, len); check_eq("ch1_pulse_high2", 32'(len), 1);
    run_len(1, 1'b0, len); check_eq("ch1_pulse_low2", 32'(len), 4);

    // ch0 at div = 9, then a mid-count write of div = 2.
    en[0] = 1'b0;
    tick();
    check_eq("ch0_disabled_out", 32'(div_out[0]), 0);
    do_write(0, 9, 1'b0);
    en[0] = 1'b1;
    wait_rise(0, found);
    check_eq("ch0_d9_rise", 32'(found), 1);
    tick();
    tick();
    do_write(0, 2, 1'b0);
    check_eq("ch0_pend_set", 32'(pend[0]), 1);
    run_len(0, 1'b1, len); check_eq("ch0_d9_half_kept", 32'(len + 3), 10);
    run_len(0, 1'b0, len); check_eq("ch0_d2_low", 32'(len), 3);
    check_eq("ch0_pend_clear", 32'(pend[0]), 0);
    run_len(0, 1'b1, len); check_eq("ch0_d2_high", 32'(len), 3);

    // Write landing on the terminal event: applies immediately, no pend.
    tick();
    tick();
    do_write(0, 5, 1'b0);
    check_eq("ch0_coinc_pend", 32'(pend[0]), 0);
    check_eq("ch0_coinc_out", 32'(div_out[0]), 1);
    run_len(0, 1'b1, len); check_eq("ch0_d5_high", 32'(len), 6);
    run_len(0, 1'b0, len); check_eq("ch0_d5_low", 32'(len), 6);

    // div = 0: pulse holds high, toggle gives clk/2.
    do_write(2, 0, 1'b1);
    en = 4'b0111;
    tick();
    tick();
    hc = 0;
    for (int i = 0; i < 8; i++) begin
      if (div_out[2]) hc++;
      tick();
    end
    check_eq("ch2_d0_pulse_const", 32'(hc), 8);
    do_write(3, 0, 1'b0);
    en = 4'b1111;
    tick();
    tick();
    run_len(3, div_out[3], len); check_eq("ch3_d0_toggle_a", 32'(len), 1);
    run_len(3, div_out[3], len); check_eq("ch3_d0_toggle_b", 32'(len), 1);

    // Build a pending reload on ch2, then reset over it with a coincident write.
    en[2] = 1'b0;
    tick();
    do_write(2, 50, 1'b0);
    en[2] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    do_write(2, 7, 1'b0);
    check_eq("ch2_pend_before_clr", 32'(pend), 32'b0100);
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_ch   = 2'd2;
    wr_div  = CNT_W'(3);
    wr_mode = 1'b0;
    tick();
    wr_en = 1'b0;
    check_eq("clr_div_out", 32'(div_out), 0);
    check_eq("clr_pend", 32'(pend), 0);
    check_eq("clr_taps", 32'(taps), 0);
    clr = 1'b0;
    en  = 4'b0100;
    // With div = DIV_RST no edge can appear this soon; the discarded div = 3 would toggle.
    hc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (div_out[2]) hc++;
    end
    check_eq("ch2_div_rst_quiet", 32'(hc), 0);
    check_eq("ch2_pend_after_clr", 32'(pend), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter N_CH, 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, 24, width of each channel terminal-count register and counter.
REQ-003 SHALL have parameter PRE_W, 23, width of the free-running prescaler counter.
REQ-004 SHALL have parameter DIV_RST, 900000, terminal count loaded into every channel at reset.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk  input  1  master clock (50 MHz).
REQ-007 SHALL have port clr  input  1  synchronous active-high reset.
REQ-008 SHALL have port en  input  N_CH  per-channel run enable.
REQ-009 SHALL have port wr_en  input  1  write strobe for the channel configuration, one cycle per write.
REQ-010 SHALL have port wr_ch  input  $clog2(N_CH)  target channel of the write.
REQ-011 SHALL have port wr_div  input  CNT_W  new terminal count.
REQ-012 SHALL have port wr_mode  input  1  new mode: 0 = toggle (square wave), 1 = pulse (one-cycle tick).
REQ-013 SHALL have port div_out  output  N_CH  per-channel divided output, registered.
REQ-014 SHALL have port pend  output  N_CH  per-channel flag: shadow configuration not yet applied.
REQ-015 SHALL have port taps  output  PRE_W  prescaler counter bits; bit k = clk / 2^(k+1).

Function
REQ-016 SHALL increment the prescaler by 1 every cycle, wrapping from all-ones to 0.
REQ-017 SHALL hold, per channel, a counter, an active (div, mode) pair and a shadow (div, mode) pair.
REQ-018 SHALL, on an enabled channel, count 0..div_act; on the cycle the counter equals div_act (terminal event) the counter returns to 0 on the next edge.
REQ-019 SHALL, in toggle mode, invert div_out on each terminal event: period = 2*(div_act+1) cycles, 50% duty.
REQ-020 SHALL, in pulse mode, drive div_out high for exactly the one cycle following each terminal event: period = div_act+1 cycles.
REQ-021 SHALL treat div_act = 0 as: toggle mode -> clk/2; pulse mode -> div_out held high continuously.
REQ-022 SHALL, when en[i] is low, hold counter[i] at 0 and div_out[i] at 0; after en[i] rises, the first terminal event occurs div_act+1 cycles later.
REQ-023 SHALL, on a write to an enabled channel, store (wr_div, wr_mode) in the shadow and set pend[i] on the next edge.
REQ-024 SHALL copy shadow to active at the next terminal event, clear pend[i], and use the new values from the following count; no output period is ever truncated.
REQ-025 SHALL, on a write to a disabled channel, load both shadow and active on the next edge and leave pend[i] low.
REQ-026 SHALL, when a write and a terminal event coincide on the same channel, load the written values directly into active, reset the counter to 0 and clear pend[i].
REQ-027 SHALL let a later write before the reload overwrite the shadow; only the last write is applied.
REQ-028 SHALL, when a mode change is applied, force div_out to 0 on the reload edge.
REQ-029 SHALL ignore writes whose wr_ch >= N_CH.

Reset
REQ-030 SHALL, on clr high at a clk edge, set the prescaler and all counters to 0, div_out to 0 and pend to 0.
REQ-031 SHALL, on reset, load active and shadow to div = DIV_RST, mode = toggle; a write coincident with clr is discarded.
REQ-032 SHALL abort any pending reload when clr is asserted mid-operation.

Structure
REQ-033 SHALL place the mode encoding (MODE_TOGGLE = 0, MODE_PULSE = 1) and the default DIV_RST in shared package clkdiv_pkg.
REQ-034 SHALL implement one channel as sub-module clkdiv_chan, instantiated N_CH times by a generate loop; the prescaler and write decode stay in the top level.

Verification
REQ-035 SHALL check: reset, en = 0001, ch0 div = 3, toggle -> div_out[0] period 8 cycles, 4 high / 4 low; taps[0] period 2.
REQ-036 SHALL check: ch1 div = 4, pulse, enabled -> div_out[1] single-cycle high every 5 cycles.
REQ-037 SHALL check: ch0 running at div = 9; write div = 2 mid-count -> pend[0] = 1 next cycle, current 10-cycle half-period completes, then half-periods of 3 cycles, pend[0] = 0.
REQ-038 SHALL check: write coincident with the terminal event -> new div takes effect immediately, pend stays 0.
REQ-039 SHALL check: div = 0 pulse -> div_out constant 1; div = 0 toggle -> clk/2.
REQ-040 SHALL check: clr asserted with pend[2] = 1 -> all outputs 0, pend = 0, ch2 div = DIV_RST after reset.
